// File: rtl/max7219_receiver_if.sv
// Serial pins, display pins and write/error strobes of the MAX7219-compatible receiver.
// master = the side driving LOAD/CLK/DIN (external driver or bench); slave = the receiver.
// Plain wires only, no logic.
interface max7219_receiver_if;
  logic       spi_clk;
  logic       din;
  logic       cs;
  logic       dout;
  logic [7:0] seg;
  logic [7:0] dig;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;

  modport master (
    output spi_clk, din, cs,
    input  dout, seg, dig, wr_valid, wr_addr, wr_data, frame_err
  );

  modport slave (
    input  spi_clk, din, cs,
    output dout, seg, dig, wr_valid, wr_addr, wr_data, frame_err
  );
endinterface

// File: rtl/max7219_receiver.sv
// MAX7219-compatible serial receiver: decodes 16-bit LOAD/CLK/DIN frames into the register file and scans 8 LED digits.
// Latency: pin cs rise to wr_valid is SYNC_STAGES+1 clk cycles; display outputs are registered (1 cycle behind the scan counters).
// Backpressure: none; every complete frame is accepted. Optional MAX7219_RECEIVER_DOUT_EN builds the 16-bit dout pass-through.
module max7219_receiver #(
  parameter int SCAN_DIV    = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  max7219_receiver_if.slave bus
);

  // Each digit slot is split into 16 PWM sub-slots of SUB_LEN clk cycles.
  localparam int SUB_LEN = SCAN_DIV / 16;
  localparam int SUBW    = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam logic [SUBW-1:0] SUB_LAST = SUBW'(SUB_LEN - 1);

  // Without the pass-through only the low 12 bits (addr + data) are ever read,
  // so the shift register is trimmed to that; with it, bit 15 feeds dout.
`ifdef MAX7219_RECEIVER_DOUT_EN
  localparam int SHW = 16;
`else
  localparam int SHW = 12;
`endif

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q,  din_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q,   cs_prev_d;

  // Frame capture
  logic [SHW-1:0]         shreg_q,     shreg_d;
  logic [4:0]             bit_cnt_q,   bit_cnt_d;
  logic                   armed_q,     armed_d;

  // Write / error strobes
  logic                   wr_valid_q,  wr_valid_d;
  logic [3:0]             wr_addr_q,   wr_addr_d;
  logic [7:0]             wr_data_q,   wr_data_d;
  logic                   frame_err_q, frame_err_d;

  // Register file
  logic [7:0][7:0]        digit_q,     digit_d;
  logic [7:0]             decode_q,    decode_d;
  logic [3:0]             intensity_q, intensity_d;
  logic [2:0]             scan_limit_q, scan_limit_d;
  logic                   shutdown_q,  shutdown_d;
  logic                   test_q,      test_d;

  // Scan timing
  logic [SUBW-1:0]        sub_cnt_q,   sub_cnt_d;
  logic [3:0]             sub_idx_q,   sub_idx_d;
  logic [2:0]             scan_dig_q,  scan_dig_d;

  // Display outputs
  logic [7:0]             seg_q,       seg_d;
  logic [7:0]             dig_q,       dig_d;

  // Combinational helpers
  logic                   sclk_s, din_s, cs_s;
  logic                   sclk_rise, cs_fall, cs_rise;
  logic                   shift_en;
  logic [4:0]             cnt_base;
  logic                   slot_end;
  logic [2:0]             limit;
  logic [7:0]             cur;
  logic [7:0]             onehot;

  // Code-B font: 0-9, '-', E, H, L, P, blank; segments {DP,A,B,C,D,E,F,G}.
  function automatic logic [7:0] code_b(input logic dp, input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h01;
      4'hB:    s = 7'h4F;
      4'hC:    s = 7'h37;
      4'hD:    s = 7'h0E;
      4'hE:    s = 7'h67;
      default: s = 7'h00;
    endcase
    return {dp, s};
  endfunction

  // Next-state logic: synchronise, capture frames, update registers, run the scan and compose the display.
  always_comb begin
    // Synchronisers: shift the pin value in at bit 0, use the oldest stage.
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0],  bus.din};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    din_s       = din_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;

    sclk_rise = sclk_s & ~sclk_prev_q;
    cs_fall   = ~cs_s & cs_prev_q;
    cs_rise   = cs_s & ~cs_prev_q;

    // A frame only counts once a cs falling edge has been seen since reset;
    // this keeps the cleared synchronisers from faking an edge after release.
    armed_d   = armed_q;
    shreg_d   = shreg_q;
    cnt_base  = cs_fall ? 5'd0 : bit_cnt_q;
    bit_cnt_d = cnt_base;
    shift_en  = sclk_rise & ~cs_s & (armed_q | cs_fall);

    if (cs_fall) begin
      armed_d = 1'b1;
    end
    if (shift_en) begin
      shreg_d = {shreg_q[SHW-2:0], din_s};
      if (cnt_base != 5'd16) begin
        bit_cnt_d = cnt_base + 5'd1;
      end
    end

    // Register file and strobes
    wr_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    digit_d      = digit_q;
    decode_d     = decode_q;
    intensity_d  = intensity_q;
    scan_limit_d = scan_limit_q;
    shutdown_d   = shutdown_q;
    test_d       = test_q;

    if (cs_rise && armed_q) begin
      armed_d = 1'b0;
      if (bit_cnt_q == 5'd16) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = shreg_q[11:8];
        wr_data_d  = shreg_q[7:0];
        case (shreg_q[11:8])
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digit_d[shreg_q[10:8] - 3'd1] = shreg_q[7:0];
          4'h9:    decode_d     = shreg_q[7:0];
          4'hA:    intensity_d  = shreg_q[3:0];
          4'hB:    scan_limit_d = shreg_q[2:0];
          4'hC:    shutdown_d   = shreg_q[0];
          4'hF:    test_d       = shreg_q[0];
          default: ;
        endcase
      end else begin
        frame_err_d = 1'b1;
      end
    end

    // Scan timing: sub-slot counter, sub-slot index, digit counter.
    sub_cnt_d  = sub_cnt_q + 1'b1;
    sub_idx_d  = sub_idx_q;
    scan_dig_d = scan_dig_q;
    slot_end   = (sub_idx_q == 4'd15) && (sub_cnt_q == SUB_LAST);
    limit      = test_q ? 3'd7 : scan_limit_q;
    if (sub_cnt_q == SUB_LAST) begin
      sub_cnt_d = '0;
      sub_idx_d = sub_idx_q + 4'd1;
    end
    // ">=" also catches a scan_limit lowered below the current digit.
    if (slot_end) begin
      scan_dig_d = (scan_dig_q >= limit) ? 3'd0 : scan_dig_q + 3'd1;
    end

    // Display composition: test overrides everything; shutdown blanks; otherwise PWM-gated.
    cur    = digit_q[scan_dig_q];
    onehot = 8'b1 << scan_dig_q;
    seg_d  = 8'h00;
    dig_d  = 8'h00;
    if (test_q) begin
      seg_d = 8'hFF;
      dig_d = onehot;
    end else if (shutdown_q && (sub_idx_q <= intensity_q)) begin
      dig_d = onehot;
      seg_d = decode_q[scan_dig_q] ? code_b(cur[7], cur[3:0]) : cur;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q  <= '0;
      din_sync_q   <= '0;
      cs_sync_q    <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      armed_q      <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_err_q  <= 1'b0;
      digit_q      <= '0;
      decode_q     <= '0;
      intensity_q  <= '0;
      scan_limit_q <= '0;
      shutdown_q   <= 1'b0;
      test_q       <= 1'b0;
      sub_cnt_q    <= '0;
      sub_idx_q    <= '0;
      scan_dig_q   <= '0;
      seg_q        <= '0;
      dig_q        <= '0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      din_sync_q   <= din_sync_d;
      cs_sync_q    <= cs_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      armed_q      <= armed_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_err_q  <= frame_err_d;
      digit_q      <= digit_d;
      decode_q     <= decode_d;
      intensity_q  <= intensity_d;
      scan_limit_q <= scan_limit_d;
      shutdown_q   <= shutdown_d;
      test_q       <= test_d;
      sub_cnt_q    <= sub_cnt_d;
      sub_idx_q    <= sub_idx_d;
      scan_dig_q   <= scan_dig_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dig       = dig_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;

`ifdef MAX7219_RECEIVER_DOUT_EN
  assign bus.dout = shreg_q[15];
`else
  assign bus.dout = 1'b0;
`endif

endmodule
